// File: rtl/swivm_console_tx.sv
// Console output device for the swivm CPU: buffers written characters in a
// small FIFO and serialises them as 8N1 UART frames on a single tx line.
module swivm_console_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level,
    output logic             busy,
    output logic             overflow,
    output logic             tx
);

    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  LEVEL_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state, w_stateNext;
    logic [BAUD_W-1:0] r_baud, w_baudNext;
    logic [2:0]        r_bitIdx, w_bitIdxNext;
    logic [7:0]        r_shift, w_shiftNext;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr, r_rdPtr;
    logic [CNT_W-1:0]  r_level;
    logic              r_overflow;

    logic              w_push, w_pop, w_full, w_empty;

    assign w_full  = (r_level == LEVEL_FULL);
    assign w_empty = (r_level == '0);
    assign w_push  = wr_en && !w_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_baud   <= w_baudNext;
            r_bitIdx <= w_bitIdxNext;
            r_shift  <= w_shiftNext;
        end
    end

    // The FIFO head is popped straight into the shift register whenever a new
    // frame begins, either from IDLE or back-to-back off the last STOP cycle.
    always_comb begin
        w_stateNext  = r_state;
        w_baudNext   = r_baud;
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shiftNext = r_mem[r_rdPtr];
                    w_baudNext  = '0;
                    w_stateNext = S_START;
                end
            end
            S_START: begin
                if (r_baud == BAUD_LAST) begin
                    w_baudNext   = '0;
                    w_bitIdxNext = '0;
                    w_stateNext  = S_DATA;
                end else begin
                    w_baudNext = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (r_baud == BAUD_LAST) begin
                    w_baudNext  = '0;
                    w_shiftNext = {1'b0, r_shift[7:1]};
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = S_STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_baudNext = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (r_baud == BAUD_LAST) begin
                    w_baudNext = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shiftNext = r_mem[r_rdPtr];
                        w_stateNext = S_START;
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end else begin
                    w_baudNext = r_baud + 1'b1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE);
    assign tx       = (r_state == S_START) ? 1'b0 :
                      (r_state == S_DATA)  ? r_shift[0] : 1'b1;

endmodule

// File: tb/tb_swivm_console_tx.sv
// Self-checking bench for swivm_console_tx: a frame-level reference model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_swivm_console_tx;

    localparam int CPB    = 4;
    localparam int DEPTH  = 4;
    localparam int CW     = 3;
    localparam int FRAME  = 10 * CPB;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] level;
    logic          busy;
    logic          overflow;
    logic          tx;

    int checks = 0;
    int errors = 0;

    swivm_console_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .busy    (busy),
        .overflow(overflow),
        .tx      (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called on a falling edge: drive inputs, then advance to the next falling edge.
    task automatic applyStimulus(input logic en, input logic [7:0] d);
        wr_en   = en;
        wr_data = d;
        @(negedge clk);
    endtask

    // Reference model: a character queue plus the current frame and its cycle count.
    logic [7:0] mq [$];
    logic       mActive = 1'b0;
    int         mFcnt = 0;
    logic [7:0] mByte = 8'h00;
    logic       mOverflow = 1'b0;
    logic       modelValid = 1'b0;
    bit         preFull, preEmpty;

    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mActive    = 1'b0;
            mFcnt      = 0;
            mByte      = 8'h00;
            mOverflow  = 1'b0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            preFull  = (mq.size() == DEPTH);
            preEmpty = (mq.size() == 0);
            if (mActive && mFcnt < FRAME - 1) begin
                mFcnt++;
            end else if (!preEmpty) begin
                mByte   = mq.pop_front();
                mActive = 1'b1;
                mFcnt   = 0;
            end else begin
                mActive = 1'b0;
            end
            if (wr_en) begin
                if (preFull) mOverflow = 1'b1;
                else mq.push_back(wr_data);
            end
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("tx",       tx,       mActive ? frameBit(mByte, mFcnt / CPB) : 1'b1);
            checkOutput("busy",     busy,     mActive);
            checkOutput("level",    level,    mq.size());
            checkOutput("full",     full,     mq.size() == DEPTH);
            checkOutput("empty",    empty,    mq.size() == 0);
            checkOutput("overflow", overflow, mOverflow);
        end
    end

    // Independent UART receiver sampling mid-bit, used to confirm byte order.
    logic [7:0] rxq [$];
    logic [7:0] rb;
    initial begin
        forever begin
            @(negedge clk);
            if (modelValid && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rb[b] = tx;
                end
                repeat (CPB) @(negedge clk);
                rxq.push_back(rb);
            end
        end
    end

    task automatic drainIdle();
        int n = 0;
        while ((mActive || mq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainBound", (n >= 3000), 1'b0);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] frame41 [10];
    logic [7:0] expRx   [$];
    int         cnt;
    int         rate;

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        repeat (3) @(negedge clk);
        checkOutput("rstTx",       tx,       1'b1);
        checkOutput("rstLevel",    level,    0);
        checkOutput("rstEmpty",    empty,    1'b1);
        checkOutput("rstOverflow", overflow, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00);
        checkOutput("rstNothingQueued", level, 0);
        checkOutput("rstIdle", busy, 1'b0);

        // Single character 0x41: start, 1,0,0,0,0,0,1,0, stop.
        frame41 = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
        applyStimulus(1'b1, 8'h41);
        wr_en = 1'b0;
        checkOutput("single.preStartTx", tx, 1'b1);
        checkOutput("single.level1", level, 1);
        @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            repeat (2) @(negedge clk);
            checkOutput("single.bit", tx, frame41[b][0]);
            if (b == 9) begin
                @(negedge clk);
                checkOutput("single.busyLastCycle", busy, 1'b1);
                @(negedge clk);
            end else begin
                repeat (2) @(negedge clk);
            end
        end
        checkOutput("single.busyFall", busy, 1'b0);
        checkOutput("single.levelZero", level, 0);

        // Back-to-back frames with no idle gap.
        drainIdle();
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b1, 8'hAA);
        wr_en = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("b2b.busyCycles", cnt, 80);

        // Fill the FIFO past capacity.
        drainIdle();
        rxq.delete();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h30 + 8'(i));
        wr_en = 1'b0;
        checkOutput("fill.level", level, 4);
        checkOutput("fill.full", full, 1'b1);
        checkOutput("fill.overflow", overflow, 1'b1);
        drainIdle();
        checkOutput("fill.overflowSticky", overflow, 1'b1);
        checkOutput("fill.rxCount", rxq.size(), 5);
        for (int i = 0; i < 5 && i < rxq.size(); i++) checkOutput("fill.rxByte", rxq[i], 8'h30 + 8'(i));

        // Push on the same edge as the STOP-to-START pop.
        rxq.delete();
        applyStimulus(1'b1, 8'hA1);
        applyStimulus(1'b1, 8'hB2);
        applyStimulus(1'b1, 8'hC3);
        wr_en = 1'b0;
        checkOutput("simul.levelBefore", level, 2);
        repeat (38) @(negedge clk);
        applyStimulus(1'b1, 8'hD4);
        wr_en = 1'b0;
        checkOutput("simul.levelHeld", level, 2);
        checkOutput("simul.busy", busy, 1'b1);
        drainIdle();
        expRx = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        checkOutput("simul.rxCount", rxq.size(), 4);
        for (int i = 0; i < 4 && i < rxq.size(); i++) checkOutput("simul.rxByte", rxq[i], expRx[i]);

        // Randomised traffic at three write rates with rare resets.
        for (int i = 0; i < 3000; i++) begin
            rate  = (i < 1000) ? 10 : (i < 2000) ? 40 : 95;
            rst_n = ($urandom_range(599) != 0);
            applyStimulus($urandom_range(99) < rate, 8'($urandom));
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
        drainIdle();

        // Reset during data bit 3 of 0xFF.
        applyStimulus(1'b1, 8'hFF);
        wr_en = 1'b0;
        repeat (18) @(negedge clk);
        checkOutput("midRst.inFrame", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midRst.tx", tx, 1'b1);
        checkOutput("midRst.level", level, 0);
        checkOutput("midRst.overflow", overflow, 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checkOutput("midRst.noResidual", {busy, tx}, 2'b01);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/swivm_console_tx.md
Name: swivm_console_tx

Overview:
- Output console device for the swivm CPU.
- Sits directly downstream of the CPU's I/O write path. The CPU writes a character byte; the block buffers it in a small FIFO and serialises it as 8N1 UART on a single tx line.
- Provides back-pressure (full) so the CPU can stall instead of losing characters.
- Used by the simulation bench and by FPGA builds to observe program output.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Minimum 2.
- FIFO_DEPTH, 8: character buffer entries. Power of 2, minimum 2.
- CNT_W, 4: width of the level output. Must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- wr_en  in  1  CPU write strobe, one character per asserted cycle
- wr_data  in  8  character byte
- full  out  1  FIFO holds FIFO_DEPTH entries; CPU must not write
- empty  out  1  FIFO holds 0 entries
- level  out  CNT_W  current FIFO occupancy
- busy  out  1  serialiser not in IDLE
- overflow  out  1  sticky: a write arrived while full
- tx  out  1  UART serial output; idle high

Behaviour:
- Reset (rst_n low at an edge):
  - Next cycle: tx=1, busy=0, full=0, empty=1, level=0, overflow=0.
  - FIFO pointers cleared; FSM in IDLE; bit and baud counters cleared.
  - Reset mid-frame aborts the frame; tx returns high the following cycle.
- All outputs are registered or decoded directly from registers. There is no combinational path from wr_en to any output.
- FIFO push:
  - On an edge with wr_en=1 and full=0 (the pre-edge value), wr_data is stored and level increments.
  - wr_en=1 while full=1: data dropped, level unchanged, overflow set to 1 and held until reset.
- FIFO pop: occurs only on the serialiser's transition into START.
- Simultaneous push and pop (full=0, empty=0): level unchanged, both take effect.
- Push into an empty FIFO with no pop is always legal.
- Pointers wrap modulo FIFO_DEPTH.
- Serialiser FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If empty=0 at an edge, pop the head into the shift register, load baud=0, go to START, drive tx=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit. Then shift right and increment the index. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
    - if empty=0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Latency:
  - A write at edge N into an empty FIFO with the FSM in IDLE gives empty=0 after edge N.
  - Pop and START at edge N+1, so tx falls after edge N+1.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
- busy=1 in START, DATA and STOP. busy=0 only in IDLE.

Test Plan:
(CLKS_PER_BIT=4, FIFO_DEPTH=4.)
- Reset:
  - Hold rst_n=0 for 3 cycles, with wr_en=1 during reset.
  - Required: tx=1, level=0, empty=1, overflow=0; nothing is queued.
- Single character:
  - Write 0x41 at edge N.
  - Required: tx low from edge N+1 for 4 cycles; bits 1,0,0,0,0,0,1,0 at 4 cycles each; tx high 4 cycles.
  - Required: busy falls at edge N+41 and level returns to 0.
- Back-to-back:
  - Write 0x55, 0xAA on consecutive cycles.
  - Required: two frames totalling 80 cycles, stop bit of frame 1 immediately followed by start bit of frame 2, no extra idle cycle.
- Full and overflow:
  - Write 6 bytes 0x30..0x35 on consecutive cycles starting in IDLE.
  - Required: 0x30 popped at the first START; FIFO fills to level=4, so full=1.
  - Required: 0x35 dropped; overflow=1 and sticky.
  - Required: 0x30..0x34 are transmitted in order.
- Simultaneous push/pop:
  - With level=2 and a pop due on the STOP→START edge, assert wr_en on that same edge.
  - Required: level stays 2; ordering is preserved.
- Reset mid-frame:
  - Assert rst_n=0 during DATA bit 3 of 0xFF.
  - Required: tx=1 the next cycle; level=0; no residual frame after rst_n deasserts.
